if_id_reg: RTL and testbench
============================

# if_id_reg

Pipeline register between the PC/instruction-fetch stage and the decode stage of the five-stage MIPS pipeline. Each cycle it captures the fetched PC, instruction word, fetch exception code (AdEL = 4 on a misaligned or out-of-range PC) and delay-slot flag, and presents them to ID. It implements hold on hazard stall, bubble insertion on flush, and a full clear on exception or interrupt entry. A faulting fetch is converted to a NOP that carries its exception code down the pipe.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, value driven on id_pc after reset and exception clear.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard stall from the hazard unit; hold all outputs.
- flush  in  1  insert a bubble, used for branch-likely annulment and eret.
- exc_flush  in  1  exception or interrupt taken in MEM; clear the stage.
- if_pc  in  32  PC of the fetched instruction.
- if_instr  in  32  instruction word read from IM.
- if_exc  in  5  fetch exception code: 0 = none, 4 = AdEL.
- if_bd  in  1  fetched instruction sits in a branch delay slot.
- id_pc  out  32  registered PC.
- id_pc8  out  32  registered PC+8, the link address for jal/jalr/bgezal.
- id_instr  out  32  registered instruction, or 0 (NOP) for bubbles and faults.
- id_exc  out  5  registered exception code.
- id_bd  out  1  registered delay-slot flag.
- id_valid  out  1  1 = real instruction, 0 = bubble.

## Operation
- One register set, updated each rising edge by the following priority (highest first).
- **reset:**
  - id_pc = RESET_PC, id_pc8 = RESET_PC+8.
  - id_instr = 0, id_exc = 0, id_bd = 0, id_valid = 0.
- **exc_flush:** same values as reset. exc_flush overrides stall.
- **stall:** every output holds its current value, including id_valid. flush is ignored while stall=1 because the branch in ID is unresolved.
- **flush:**
  - id_pc = if_pc, id_pc8 = if_pc+8, so the bubble keeps a valid EPC candidate.
  - id_instr = 0, id_exc = 0, id_bd = 0, id_valid = 0.
- **load (none of the above):**
  - id_pc = if_pc, id_pc8 = if_pc + 32'd8 (mod 2^32, carry out discarded).
  - id_bd = if_bd, id_valid = 1.
  - If if_exc != 0: id_instr = 0 and id_exc = if_exc, so no side effects occur in later stages.
  - Otherwise: id_instr = if_instr and id_exc = 0.
- id_pc8 is computed from the incoming if_pc at load time, not combinationally from id_pc.
- No state machine beyond the register set. The bubble/valid state is fully described by id_valid.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N and are stable until edge N+1.
- All outputs are registered; there is no combinational path from input to output.
- **stall held for k cycles:** outputs are unchanged for k edges. The load happens on the first edge with stall=0.
- **exc_flush and stall in the same cycle:** the clear wins, and the stage is empty on the next cycle.
- **reset asserted mid-stall or mid-flush:** reset values apply at the next edge.
- **flush for consecutive cycles:** a bubble every cycle. id_pc tracks if_pc.
- **if_pc = 32'hFFFF_FFFC:** id_pc8 = 32'h0000_0004 (wrap). if_exc is expected to be 4 in this case.

## Test plan
- **Reset:** reset=1 for 2 edges -> id_pc=0x3000, id_pc8=0x3008, id_instr=0, id_exc=0, id_valid=0.
- **Normal load:** if_pc=0x3004, if_instr=0x24010001, if_exc=0, if_bd=1 -> next cycle id_pc=0x3004, id_pc8=0x300C, id_instr=0x24010001, id_bd=1, id_valid=1.
- **Fetch fault:** if_pc=0x3002, if_exc=4, if_instr=0xDEADBEEF -> id_instr=0, id_exc=4, id_pc=0x3002, id_valid=1.
- **Stall hold:** load 0x3008, then stall=1 for 3 cycles while if_pc=0x300C -> outputs stay at 0x3008 for 3 cycles. The cycle after stall drops, id_pc=0x300C.
- **Priority:** stall=1, flush=1 -> hold. Then stall=1, exc_flush=1 -> cleared (id_instr=0, id_valid=0, id_pc=0x3000). Then flush=1 with if_pc=0x3010 -> id_pc=0x3010, id_valid=0.
- **Wrap:** if_pc=0xFFFF_FFFC, if_exc=4 -> id_pc8=0x0000_0004, id_exc=4, id_instr=0.

Source files
------------

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// Pipeline register between instruction fetch (IF) and decode (ID).
// Captures the fetched PC, instruction word, fetch exception code and
// delay-slot flag. It holds on stall, inserts a bubble on flush, and clears
// completely on exception/interrupt entry. A faulting fetch becomes a NOP
// that carries its exception code down the pipe.
//
// Ports:
//   clk        in   1   clock, rising edge
//   reset      in   1   synchronous, active-high
//   stall      in   1   hold every output
//   flush      in   1   insert bubble (ignored while stall=1)
//   exc_flush  in   1   clear stage to reset state (overrides stall)
//   if_pc      in  32   PC of the fetched instruction
//   if_instr   in  32   instruction word from IM
//   if_exc     in   5   fetch exception code (0 = none, 4 = AdEL)
//   if_bd      in   1   fetched instruction sits in a delay slot
//   id_pc      out 32   registered PC
//   id_pc8     out 32   registered PC+8 (link address)
//   id_instr   out 32   registered instruction, 0 for bubbles and faults
//   id_exc     out  5   registered exception code
//   id_bd      out  1   registered delay-slot flag
//   id_valid   out  1   1 = real instruction, 0 = bubble
// ---------------------------------------------------------------------------
module if_id_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        exc_flush,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    input  logic [4:0]  if_exc,
    input  logic        if_bd,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8,
    output logic [31:0] id_instr,
    output logic [4:0]  id_exc,
    output logic        id_bd,
    output logic        id_valid
);

    logic [31:0] pc_d, pc_q;
    logic [31:0] pc8_d, pc8_q;
    logic [31:0] instr_d, instr_q;
    logic [4:0]  exc_d, exc_q;
    logic        bd_d, bd_q;
    logic        valid_d, valid_q;

    // Link address comes from the incoming PC; carry out is discarded so
    // 0xFFFF_FFFC wraps to 0x0000_0004.
    logic [31:0] if_pc8;
    assign if_pc8 = if_pc + 32'd8;

    always_comb begin
        // Default: hold (covers stall).
        pc_d    = pc_q;
        pc8_d   = pc8_q;
        instr_d = instr_q;
        exc_d   = exc_q;
        bd_d    = bd_q;
        valid_d = valid_q;

        if (reset || exc_flush) begin
            pc_d    = RESET_PC;
            pc8_d   = RESET_PC + 32'd8;
            instr_d = 32'd0;
            exc_d   = 5'd0;
            bd_d    = 1'b0;
            valid_d = 1'b0;
        end else if (stall) begin
            // Branch in ID unresolved: hold, and ignore flush.
        end else if (flush) begin
            // Bubble keeps the fetched PC as a valid EPC candidate.
            pc_d    = if_pc;
            pc8_d   = if_pc8;
            instr_d = 32'd0;
            exc_d   = 5'd0;
            bd_d    = 1'b0;
            valid_d = 1'b0;
        end else begin
            pc_d    = if_pc;
            pc8_d   = if_pc8;
            bd_d    = if_bd;
            valid_d = 1'b1;
            if (if_exc != 5'd0) begin
                // Faulting fetch becomes a NOP so later stages see no side effects.
                instr_d = 32'd0;
                exc_d   = if_exc;
            end else begin
                instr_d = if_instr;
                exc_d   = 5'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        pc8_q   <= pc8_d;
        instr_q <= instr_d;
        exc_q   <= exc_d;
        bd_q    <= bd_d;
        valid_q <= valid_d;
    end

    assign id_pc    = pc_q;
    assign id_pc8   = pc8_q;
    assign id_instr = instr_q;
    assign id_exc   = exc_q;
    assign id_bd    = bd_q;
    assign id_valid = valid_q;

endmodule

// File: tb/tb_if_id_reg.sv
// ---------------------------------------------------------------------------
// tb_if_id_reg
// Directed-vector bench for if_id_reg. Each vector drives one cycle of
// inputs and pushes its hand-computed expected outputs into a queue; a
// monitor pops one entry per clock edge and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_if_id_reg;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        exc_flush;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [4:0]  if_exc;
    logic        if_bd;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;
    logic [31:0] id_instr;
    logic [4:0]  id_exc;
    logic        id_bd;
    logic        id_valid;

    if_id_reg #(
        .RESET_PC(32'h0000_3000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .flush    (flush),
        .exc_flush(exc_flush),
        .if_pc    (if_pc),
        .if_instr (if_instr),
        .if_exc   (if_exc),
        .if_bd    (if_bd),
        .id_pc    (id_pc),
        .id_pc8   (id_pc8),
        .id_instr (id_instr),
        .id_exc   (id_exc),
        .id_bd    (id_bd),
        .id_valid (id_valid)
    );

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic        bd;
        logic        valid;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string nm, input string fld, input logic [31:0] act,
                         input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, req);
        end
    endtask

    // Monitor: outputs are valid every cycle, so pop one expectation per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk32(e.name, "id_pc",    id_pc,           e.pc);
                chk32(e.name, "id_pc8",   id_pc8,          e.pc8);
                chk32(e.name, "id_instr", id_instr,        e.instr);
                chk32(e.name, "id_exc",   {27'd0, id_exc}, {27'd0, e.exc});
                chk32(e.name, "id_bd",    {31'd0, id_bd},  {31'd0, e.bd});
                chk32(e.name, "id_valid", {31'd0, id_valid}, {31'd0, e.valid});
            end
        end
    end

    task automatic vec(input string nm,
                       input logic r, input logic st, input logic fl, input logic ef,
                       input logic [31:0] pc, input logic [31:0] ins,
                       input logic [4:0] ex, input logic bd,
                       input logic [31:0] e_pc, input logic [31:0] e_pc8,
                       input logic [31:0] e_ins, input logic [4:0] e_ex,
                       input logic e_bd, input logic e_v);
        exp_t e;
        @(negedge clk);
        reset     = r;
        stall     = st;
        flush     = fl;
        exc_flush = ef;
        if_pc     = pc;
        if_instr  = ins;
        if_exc    = ex;
        if_bd     = bd;
        e.name  = nm;
        e.pc    = e_pc;
        e.pc8   = e_pc8;
        e.instr = e_ins;
        e.exc   = e_ex;
        e.bd    = e_bd;
        e.valid = e_v;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; exc_flush = 1'b0;
        if_pc = 32'h0; if_instr = 32'h0; if_exc = 5'd0; if_bd = 1'b0;

        //   name          rst st fl ef if_pc         if_instr      exc  bd   id_pc         id_pc8        id_instr      exc  bd v
        vec("reset0",      1, 0, 0, 0, 32'h0000_1234, 32'h1111_1111, 5'd0, 1, 32'h0000_3000, 32'h0000_3008, 32'h0,        5'd0, 0, 0);
        vec("reset1",      1, 0, 1, 0, 32'h0000_5678, 32'h2222_2222, 5'd4, 1, 32'h0000_3000, 32'h0000_3008, 32'h0,        5'd0, 0, 0);
        vec("load",        0, 0, 0, 0, 32'h0000_3004, 32'h2401_0001, 5'd0, 1, 32'h0000_3004, 32'h0000_300C, 32'h2401_0001, 5'd0, 1, 1);
        vec("fault",       0, 0, 0, 0, 32'h0000_3002, 32'hDEAD_BEEF, 5'd4, 0, 32'h0000_3002, 32'h0000_300A, 32'h0,        5'd4, 0, 1);
        vec("load3008",    0, 0, 0, 0, 32'h0000_3008, 32'h0000_0020, 5'd0, 0, 32'h0000_3008, 32'h0000_3010, 32'h0000_0020, 5'd0, 0, 1);
        vec("stall1",      0, 1, 0, 0, 32'h0000_300C, 32'h8C22_0004, 5'd0, 1, 32'h0000_3008, 32'h0000_3010, 32'h0000_0020, 5'd0, 0, 1);
        vec("stall2",      0, 1, 0, 0, 32'h0000_300C, 32'h8C22_0004, 5'd0, 1, 32'h0000_3008, 32'h0000_3010, 32'h0000_0020, 5'd0, 0, 1);
        vec("stall3",      0, 1, 0, 0, 32'h0000_300C, 32'h8C22_0004, 5'd0, 1, 32'h0000_3008, 32'h0000_3010, 32'h0000_0020, 5'd0, 0, 1);
        vec("unstall",     0, 0, 0, 0, 32'h0000_300C, 32'h8C22_0004, 5'd0, 1, 32'h0000_300C, 32'h0000_3014, 32'h8C22_0004, 5'd0, 1, 1);
        vec("stall_flush", 0, 1, 1, 0, 32'h0000_3010, 32'h3333_3333, 5'd0, 0, 32'h0000_300C, 32'h0000_3014, 32'h8C22_0004, 5'd0, 1, 1);
        vec("stall_excf",  0, 1, 0, 1, 32'h0000_3010, 32'h3333_3333, 5'd0, 1, 32'h0000_3000, 32'h0000_3008, 32'h0,        5'd0, 0, 0);
        vec("flush0",      0, 0, 1, 0, 32'h0000_3010, 32'h1111_1111, 5'd0, 1, 32'h0000_3010, 32'h0000_3018, 32'h0,        5'd0, 0, 0);
        vec("flush1",      0, 0, 1, 0, 32'h0000_3014, 32'h4444_4444, 5'd4, 1, 32'h0000_3014, 32'h0000_301C, 32'h0,        5'd0, 0, 0);
        vec("wrap",        0, 0, 0, 0, 32'hFFFF_FFFC, 32'h1234_5678, 5'd4, 1, 32'hFFFF_FFFC, 32'h0000_0004, 32'h0,        5'd4, 1, 1);
        vec("load3020",    0, 0, 0, 0, 32'h0000_3020, 32'hAAAA_0000, 5'd0, 0, 32'h0000_3020, 32'h0000_3028, 32'hAAAA_0000, 5'd0, 0, 1);
        vec("reset_stall", 1, 1, 0, 0, 32'h0000_3024, 32'h5555_5555, 5'd0, 1, 32'h0000_3000, 32'h0000_3008, 32'h0,        5'd0, 0, 0);
        vec("load3024",    0, 0, 0, 0, 32'h0000_3024, 32'h0000_0BCD, 5'd0, 1, 32'h0000_3024, 32'h0000_302C, 32'h0000_0BCD, 5'd0, 1, 1);
        vec("excf",        0, 0, 1, 1, 32'h0000_3028, 32'h6666_6666, 5'd0, 1, 32'h0000_3000, 32'h0000_3008, 32'h0,        5'd0, 0, 0);
        vec("reload",      0, 0, 0, 0, 32'h0000_3030, 32'h0062_0821, 5'd0, 0, 32'h0000_3030, 32'h0000_3038, 32'h0062_0821, 5'd0, 0, 1);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
